// File: rtl/xadc_axil_pkg.sv
// Shared constants and types for the XADC sample-capture AXI4-Lite block.
// Register offsets, CTRL bit positions, response codes and the channel register layout.
package xadc_axil_pkg;

    localparam int MAX_CHANNELS     = 16;
    localparam int MAX_SAMPLE_WIDTH = 16;

    localparam int OFF_CTRL    = 'h00;
    localparam int OFF_STATUS  = 'h04;
    localparam int OFF_COUNT   = 'h08;
    localparam int OFF_SCRATCH = 'h0C;
    localparam int OFF_CH_BASE = 'h10;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FREEZE_BIT = 1;
    localparam int CTRL_CLEAR_BIT  = 2;
    localparam int CTRL_IRQ_EN_BIT = 3;

    localparam int STATUS_BAD_BIT = 31;
    localparam int CH_NEW_BIT     = 31;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic                        new_flag;
        logic [MAX_SAMPLE_WIDTH-1:0] data;
    } chan_reg_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_EXEC,
        WR_RESP
    } wr_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_slave_port.sv
// AXI4-Lite slave handshake engine: turns AW/W/B and AR/R traffic into one-cycle
// register write and read strobes, with a single outstanding write and read.
module axil_slave_port
    import xadc_axil_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] s00_axi_awaddr,
    input  logic [2:0]        s00_axi_awprot,
    input  logic              s00_axi_awvalid,
    output logic              s00_axi_awready,
    input  logic [31:0]       s00_axi_wdata,
    input  logic [3:0]        s00_axi_wstrb,
    input  logic              s00_axi_wvalid,
    output logic              s00_axi_wready,
    output logic [1:0]        s00_axi_bresp,
    output logic              s00_axi_bvalid,
    input  logic              s00_axi_bready,
    input  logic [ADDR_W-1:0] s00_axi_araddr,
    input  logic [2:0]        s00_axi_arprot,
    input  logic              s00_axi_arvalid,
    output logic              s00_axi_arready,
    output logic [31:0]       s00_axi_rdata,
    output logic [1:0]        s00_axi_rresp,
    output logic              s00_axi_rvalid,
    input  logic              s00_axi_rready,

    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_strb_o,
    input  logic              wr_err_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       rd_data_i,
    input  logic              rd_err_i
);

    wr_state_e         wr_state_q, wr_state_d;
    logic              live_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic              aw_hs, w_hs, ar_hs;
    logic              unused_prot;

    assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot};

    // live_q keeps every ready low while reset is asserted and for the first cycle after.
    assign s00_axi_awready = live_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_W);
    assign s00_axi_wready  = live_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_AW);
    assign s00_axi_arready = live_q && !rvalid_q;
    assign s00_axi_bvalid  = (wr_state_q == WR_RESP);
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    assign wr_en_o   = (wr_state_q == WR_EXEC);
    assign wr_addr_o = awaddr_q;
    assign wr_data_o = wdata_q;
    assign wr_strb_o = wstrb_q;
    assign rd_en_o   = ar_hs;
    assign rd_addr_o = s00_axi_araddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            live_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            live_q     <= 1'b1;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_EXEC;
                else if (aw_hs)    wr_state_d = WR_HAVE_AW;
                else if (w_hs)     wr_state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_hs)  wr_state_d = WR_EXEC;
            WR_HAVE_W:  if (aw_hs) wr_state_d = WR_EXEC;
            WR_EXEC:    wr_state_d = WR_RESP;
            WR_RESP:    if (s00_axi_bready) wr_state_d = WR_IDLE;
            default:    wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) awaddr_q <= s00_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            if (wr_state_q == WR_EXEC) bresp_q <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_i;
            rresp_q  <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/xadc_axil_capture.sv
// Per-channel ADC sample capture with NEW/overrun tracking and a sample counter,
// exposed as a polled register file over AXI4-Lite.
module xadc_axil_capture
    import xadc_axil_pkg::*;
#(
    parameter int NUM_CHANNELS         = 4,
    parameter int SAMPLE_WIDTH         = 12,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 7
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
    input  logic [3:0]                      s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic                            sample_valid,
    input  logic [3:0]                      sample_channel,
    input  logic [SAMPLE_WIDTH-1:0]         sample_data,
    output logic                            irq
);

    localparam int ADDR_W = C_S00_AXI_ADDR_WIDTH;
    localparam int IDX_W  = ADDR_W - 2;
    // One extra bit so the limit is representable even when the map fills the address space.
    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(OFF_CH_BASE/4 + NUM_CHANNELS);

    logic              wr_en, wr_err, rd_en, rd_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data, rd_data;
    logic [3:0]        wr_strb;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              unused_addr_lsb;

    logic        enable_q, enable_d;
    logic        freeze_q, freeze_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] count_q, count_d;
    logic        bad_q, bad_d;
    logic [NUM_CHANNELS-1:0] overrun_q, overrun_d;
    chan_reg_t   chan_q [NUM_CHANNELS];
    chan_reg_t   chan_d [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] cap_hit, rd_clr, new_vec;
    logic ctrl_wr, scratch_wr, clear_pulse, cap_en, ch_ok;
    logic [31:0] ctrl_word, status_word, ctrl_new;

    axil_slave_port #(.ADDR_W(ADDR_W)) u_port (
        .clk             (s00_axi_aclk),
        .rst_n           (s00_axi_aresetn),
        .s00_axi_awaddr  (s00_axi_awaddr),
        .s00_axi_awprot  (s00_axi_awprot),
        .s00_axi_awvalid (s00_axi_awvalid),
        .s00_axi_awready (s00_axi_awready),
        .s00_axi_wdata   (s00_axi_wdata),
        .s00_axi_wstrb   (s00_axi_wstrb),
        .s00_axi_wvalid  (s00_axi_wvalid),
        .s00_axi_wready  (s00_axi_wready),
        .s00_axi_bresp   (s00_axi_bresp),
        .s00_axi_bvalid  (s00_axi_bvalid),
        .s00_axi_bready  (s00_axi_bready),
        .s00_axi_araddr  (s00_axi_araddr),
        .s00_axi_arprot  (s00_axi_arprot),
        .s00_axi_arvalid (s00_axi_arvalid),
        .s00_axi_arready (s00_axi_arready),
        .s00_axi_rdata   (s00_axi_rdata),
        .s00_axi_rresp   (s00_axi_rresp),
        .s00_axi_rvalid  (s00_axi_rvalid),
        .s00_axi_rready  (s00_axi_rready),
        .wr_en_o         (wr_en),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .wr_strb_o       (wr_strb),
        .wr_err_i        (wr_err),
        .rd_en_o         (rd_en),
        .rd_addr_o       (rd_addr),
        .rd_data_i       (rd_data),
        .rd_err_i        (rd_err)
    );

    assign wr_idx          = wr_addr[ADDR_W-1:2];
    assign rd_idx          = rd_addr[ADDR_W-1:2];
    assign unused_addr_lsb = ^{wr_addr[1:0], rd_addr[1:0]};

    assign wr_err      = ({1'b0, wr_idx} >= IDX_LIMIT);
    assign rd_err      = ({1'b0, rd_idx} >= IDX_LIMIT);
    assign ctrl_wr     = wr_en && (wr_idx == IDX_W'(OFF_CTRL/4));
    assign scratch_wr  = wr_en && (wr_idx == IDX_W'(OFF_SCRATCH/4));
    assign clear_pulse = ctrl_wr && wr_strb[0] && wr_data[CTRL_CLEAR_BIT];
    assign cap_en      = sample_valid && enable_q && !freeze_q;
    assign ch_ok       = ({1'b0, sample_channel} < 5'(NUM_CHANNELS));

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign cap_hit[gi] = cap_en && (sample_channel == 4'(gi));
            assign rd_clr[gi]  = rd_en && (rd_idx == IDX_W'(OFF_CH_BASE/4 + gi));
            assign new_vec[gi] = chan_q[gi].new_flag;
        end
    endgenerate

    assign irq = irq_en_q && (|new_vec);

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_ENABLE_BIT] = enable_q;
        ctrl_word[CTRL_FREEZE_BIT] = freeze_q;
        ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;
        status_word = '0;
        status_word[NUM_CHANNELS-1:0] = overrun_q;
        status_word[STATUS_BAD_BIT]   = bad_q;
    end

    always_comb begin
        rd_data = '0;
        if (!rd_err) begin
            case (rd_idx)
                IDX_W'(OFF_CTRL/4):    rd_data = ctrl_word;
                IDX_W'(OFF_STATUS/4):  rd_data = status_word;
                IDX_W'(OFF_COUNT/4):   rd_data = count_q;
                IDX_W'(OFF_SCRATCH/4): rd_data = scratch_q;
                default: begin
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        if (rd_idx == IDX_W'(OFF_CH_BASE/4 + k)) begin
                            rd_data[CH_NEW_BIT]             = chan_q[k].new_flag;
                            rd_data[MAX_SAMPLE_WIDTH-1:0]   = chan_q[k].data;
                        end
                    end
                end
            endcase
        end
    end

    // Capture beats read-clear on the same channel; clear beats capture for counters/flags.
    always_comb begin
        ctrl_new  = apply_strb(ctrl_word, wr_data, wr_strb);
        enable_d  = ctrl_wr ? ctrl_new[CTRL_ENABLE_BIT] : enable_q;
        freeze_d  = ctrl_wr ? ctrl_new[CTRL_FREEZE_BIT] : freeze_q;
        irq_en_d  = ctrl_wr ? ctrl_new[CTRL_IRQ_EN_BIT] : irq_en_q;
        scratch_d = scratch_wr ? apply_strb(scratch_q, wr_data, wr_strb) : scratch_q;

        count_d = count_q;
        bad_d   = bad_q;
        if (clear_pulse) begin
            count_d = '0;
            bad_d   = 1'b0;
        end else if (cap_en && ch_ok) begin
            count_d = count_q + 32'd1;
        end else if (cap_en) begin
            bad_d = 1'b1;
        end

        for (int k = 0; k < NUM_CHANNELS; k++) begin
            chan_d[k]    = chan_q[k];
            overrun_d[k] = overrun_q[k];
            if (cap_hit[k]) begin
                chan_d[k].data     = MAX_SAMPLE_WIDTH'(sample_data);
                chan_d[k].new_flag = 1'b1;
                if (chan_q[k].new_flag) overrun_d[k] = 1'b1;
            end else if (rd_clr[k]) begin
                chan_d[k].new_flag = 1'b0;
            end
            if (clear_pulse) overrun_d[k] = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            enable_q  <= 1'b0;
            freeze_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            scratch_q <= '0;
            count_q   <= '0;
            bad_q     <= 1'b0;
            overrun_q <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) chan_q[k] <= '0;
        end else begin
            enable_q  <= enable_d;
            freeze_q  <= freeze_d;
            irq_en_q  <= irq_en_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bad_q     <= bad_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < NUM_CHANNELS; k++) chan_q[k] <= chan_d[k];
        end
    end

endmodule

// File: tb/tb_xadc_axil_capture.sv
// Scoreboard bench for xadc_axil_capture: stimulus queues expected responses,
// an independent monitor pops and compares on every R and B handshake.
module tb_xadc_axil_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        sample_valid = 1'b0;
    logic [3:0]  sample_channel = '0;
    logic [11:0] sample_data = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rdata_q [$];
    logic [1:0]  exp_rresp_q [$];
    string       exp_rname_q [$];
    logic [1:0]  exp_bresp_q [$];
    string       exp_bname_q [$];

    always #5 clk = ~clk;

    xadc_axil_capture dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .sample_valid    (sample_valid),
        .sample_channel  (sample_channel),
        .sample_data     (sample_data),
        .irq             (irq)
    );

    // Monitor: one comparison per R or B handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid && rready) begin
                checks++;
                if (exp_rdata_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: got rdata=%h rresp=%0d, required no response", rdata, rresp);
                end else begin
                    automatic logic [31:0] ed = exp_rdata_q.pop_front();
                    automatic logic [1:0]  er = exp_rresp_q.pop_front();
                    automatic string       nm = exp_rname_q.pop_front();
                    if (rdata !== ed || rresp !== er) begin
                        errors++;
                        $display("FAIL read_%s: got rdata=%h rresp=%0d, required rdata=%h rresp=%0d", nm, rdata, rresp, ed, er);
                    end else begin
                        $display("read  %-12s rdata=%h rresp=%0d", nm, rdata, rresp);
                    end
                end
            end
            if (bvalid && bready) begin
                checks++;
                if (exp_bresp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write_resp: got bresp=%0d, required no response", bresp);
                end else begin
                    automatic logic [1:0] eb = exp_bresp_q.pop_front();
                    automatic string      nm = exp_bname_q.pop_front();
                    if (bresp !== eb) begin
                        errors++;
                        $display("FAIL write_%s: got bresp=%0d, required %0d", nm, bresp, eb);
                    end else begin
                        $display("write %-12s bresp=%0d", nm, bresp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT handshake", name);
    endtask

    task automatic axi_write(input string name, input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        int  t;
        logic aw_hs, w_hs;
        exp_bresp_q.push_back(resp);
        exp_bname_q.push_back(name);
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        t = 0;
        while ((awvalid || wvalid) && t < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            t++;
        end
        if (t >= 50) begin
            timeout({name, "_awready"});
            awvalid = 1'b0; wvalid = 1'b0;
        end
        t = 0;
        while (!bvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout({name, "_bvalid"});
        @(negedge clk);
    endtask

    task automatic axi_read(input string name, input logic [6:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input logic with_sample,
                            input logic [3:0] s_ch, input logic [11:0] s_data);
        int   t;
        logic ar_hs;
        exp_rdata_q.push_back(data);
        exp_rresp_q.push_back(resp);
        exp_rname_q.push_back(name);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        if (with_sample) begin
            sample_valid = 1'b1; sample_channel = s_ch; sample_data = s_data;
        end
        t = 0;
        while (arvalid && t < 50) begin
            ar_hs = arready;
            @(negedge clk);
            sample_valid = 1'b0;
            if (ar_hs) arvalid = 1'b0;
            t++;
        end
        if (t >= 50) begin
            timeout({name, "_arready"});
            arvalid = 1'b0;
        end
        t = 0;
        while (!rvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout({name, "_rvalid"});
        @(negedge clk);
    endtask

    task automatic sample(input logic [3:0] ch, input logic [11:0] d);
        @(negedge clk);
        sample_valid = 1'b1; sample_channel = ch; sample_data = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        int t;

        // Reset state
        repeat (3) @(negedge clk);
        check("awready_in_reset", {31'b0, awready}, 32'd0);
        check("arready_in_reset", {31'b0, arready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bvalid_after_reset", {31'b0, bvalid}, 32'd0);
        check("rvalid_after_reset", {31'b0, rvalid}, 32'd0);
        check("irq_after_reset", {31'b0, irq}, 32'd0);
        check("awready_idle", {31'b0, awready}, 32'd1);
        for (int a = 0; a < 8; a++) begin
            axi_read($sformatf("reset_%02h", a*4), 7'(a*4), 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        end

        // Basic capture, NEW flag, COUNT, irq
        axi_write("ctrl_9", 7'h00, 32'h9, 4'hF, 2'b00);
        sample(4'd2, 12'hABC);
        check("irq_after_sample", {31'b0, irq}, 32'd1);
        axi_read("ch2_new", 7'h18, 32'h8000_0ABC, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("count_1", 7'h08, 32'h1, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("ch2_old", 7'h18, 32'h0000_0ABC, 2'b00, 1'b0, 4'd0, 12'd0);
        check("irq_after_read", {31'b0, irq}, 32'd0);

        // Overrun and clear
        sample(4'd1, 12'h111);
        sample(4'd1, 12'h222);
        axi_read("status_ovr1", 7'h04, 32'h0000_0002, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("count_3", 7'h08, 32'h3, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("ch1_222", 7'h14, 32'h8000_0222, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_write("ctrl_clear", 7'h00, 32'hD, 4'hF, 2'b00);
        axi_read("status_clr", 7'h04, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("count_clr", 7'h08, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("ctrl_9", 7'h00, 32'h9, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("ch1_keep", 7'h14, 32'h0000_0222, 2'b00, 1'b0, 4'd0, 12'd0);

        // Bad channel and out-of-map accesses
        sample(4'd7, 12'h123);
        axi_read("status_bad", 7'h04, 32'h8000_0000, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("count_bad", 7'h08, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("ch3_last", 7'h1C, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("oor_20", 7'h20, 32'h0, 2'b10, 1'b0, 4'd0, 12'd0);
        axi_write("oor_20", 7'h20, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_write("ro_status", 7'h04, 32'hFFFF_FFFF, 4'hF, 2'b00);
        axi_read("status_ro", 7'h04, 32'h8000_0000, 2'b00, 1'b0, 4'd0, 12'd0);

        // W three cycles before AW, bready held low
        exp_bresp_q.push_back(2'b00);
        exp_bname_q.push_back("scratch_w1st");
        @(negedge clk);
        bready = 1'b0;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("wready_after_w", {31'b0, wready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        awaddr = 7'h0C; awvalid = 1'b1;
        check("awready_before_aw", {31'b0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("scratch_w1st_bvalid");
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bvalid_hold_%0d", c), {31'b0, bvalid}, 32'd1);
            check($sformatf("ready_block_%0d", c), {30'b0, awready, wready}, 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bvalid_done", {31'b0, bvalid}, 32'd0);
        axi_read("scratch_full", 7'h0C, 32'hDEAD_BEEF, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_write("scratch_b0", 7'h0C, 32'h0000_0055, 4'h1, 2'b00);
        axi_read("scratch_b0", 7'h0C, 32'hDEAD_BE55, 2'b00, 1'b0, 4'd0, 12'd0);

        // Capture in the same cycle as the CH0 read
        axi_read("ch0_race", 7'h10, 32'h0, 2'b00, 1'b1, 4'd0, 12'h5A5);
        axi_read("ch0_after", 7'h10, 32'h8000_05A5, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("status_race", 7'h04, 32'h8000_0000, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("count_race", 7'h08, 32'h1, 2'b00, 1'b0, 4'd0, 12'd0);

        // Freeze drops samples
        axi_write("ctrl_freeze", 7'h00, 32'h3, 4'hF, 2'b00);
        sample(4'd3, 12'h7FF);
        axi_read("ch3_frozen", 7'h1C, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("count_frozen", 7'h08, 32'h1, 2'b00, 1'b0, 4'd0, 12'd0);

        // Reset in the middle of a write
        @(negedge clk);
        awaddr = 7'h0C; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("bvalid_in_reset", {31'b0, bvalid}, 32'd0);
        check("irq_in_reset", {31'b0, irq}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bvalid_post_reset", {31'b0, bvalid}, 32'd0);
        axi_read("ctrl_rst", 7'h00, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("status_rst", 7'h04, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("count_rst", 7'h08, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("scratch_rst", 7'h0C, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("ch0_rst", 7'h10, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);
        axi_read("ch1_rst", 7'h14, 32'h0, 2'b00, 1'b0, 4'd0, 12'd0);

        repeat (3) @(negedge clk);
        check("pending_reads", exp_rdata_q.size(), 32'd0);
        check("pending_writes", exp_bresp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
